// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline.
// Fetch state encoding and IF/ID bundle layout.
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    PC_RESET  = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc4;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > stall (hold) > load > bubble.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t bubble;

  assign bubble = '{instr: NOP, pc4: '0, valid: 1'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= bubble;
    end else if (flush) begin
      q <= bubble;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      q <= bubble;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake,
// stall hold buffer and IF/ID register.
module if_stage #(
  parameter logic [31:0] PC_RESET  = pipe_pkg::PC_RESET,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_pc4,
  output logic        ID_valid
);

  import pipe_pkg::*;

  fetch_state_e state, state_n;

  logic [31:0] pc, pc_n, pc_plus4, target;
  logic [31:0] req_addr;
  logic [31:0] hold_instr, hold_pc4;
  logic        req_en, ack_v, load, hold_ld;
  if_id_t      if_id_d, if_id_q;

  assign pc_plus4 = pc + 32'd4;
  assign target   = {redirect_pc_i[31:2], 2'b00};

  // req_en keeps imem_req low for the first cycle after reset release
  assign imem_req  = req_en && (state != S_HOLD);
  assign imem_addr = (state == S_DROP) ? req_addr : pc;
  assign ack_v     = imem_ack && imem_req;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    load    = 1'b0;
    hold_ld = 1'b0;
    if_id_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
    unique case (state)
      S_REQ: begin
        if (ack_v) begin
          if (redirect_i) begin
            pc_n = target;
          end else if (!stall_i) begin
            load = 1'b1;
            pc_n = pc_plus4;
          end else begin
            hold_ld = 1'b1;
            pc_n    = pc_plus4;
            state_n = S_HOLD;
          end
        end else if (redirect_i) begin
          pc_n = target;
          if (req_en) state_n = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect_i) pc_n = target;
        if (ack_v) state_n = S_REQ;
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (!stall_i) begin
          load    = 1'b1;
          if_id_d = '{instr: hold_instr,
                      pc4:   hold_pc4,
                      valid: 1'b1};
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_REQ;
      pc         <= PC_RESET;
      req_addr   <= PC_RESET;
      req_en     <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc4   <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_en <= 1'b1;
      // remembers the in-flight address once pc moves to a target
      if (state == S_REQ) req_addr <= pc;
      if (hold_ld) begin
        hold_instr <= imem_rdata;
        hold_pc4   <= pc_plus4;
      end
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .flush(flush_i),
    .stall(stall_i),
    .load (load),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign ID_instruction = if_id_q.instr;
  assign ID_pc4         = if_id_q.pc4;
  assign ID_valid       = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: cycle vector table with
// scoreboard queue, plus reset and PC-wrap sequences.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ID_instruction, ID_pc4;
  logic        ID_valid;

  logic        rst2, ack2;
  logic        req2;
  logic [31:0] addr2, rdata2;
  logic [31:0] instr2, pc4_2;
  logic        valid2;
  logic        zero2;
  logic [31:0] zpc2;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] iw(logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign imem_rdata = iw(imem_addr);
  assign rdata2     = iw(addr2);

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ID_instruction(ID_instruction),
    .ID_pc4        (ID_pc4),
    .ID_valid      (ID_valid)
  );

  if_stage #(
    .PC_RESET(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .stall_i       (zero2),
    .flush_i       (zero2),
    .redirect_i    (zero2),
    .redirect_pc_i (zpc2),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_ack      (ack2),
    .imem_rdata    (rdata2),
    .ID_instruction(instr2),
    .ID_pc4        (pc4_2),
    .ID_valid      (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t vt[20];
  vec_t sb[$];

  function automatic vec_t mk(
    logic s, logic f, logic r, logic [31:0] rp,
    logic a, logic eq, logic [31:0] ea,
    logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.stall = s;  v.flush = f;  v.redir = r;
    v.rpc = rp;   v.ack = a;    v.e_req = eq;
    v.e_addr = ea; v.e_v = ev;
    v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  initial begin
    vec_t e;
    logic [31:0] B;
    B = 32'h0;
    rst = 1'b0;  rst2 = 1'b0;
    stall_i = 0; flush_i = 0; redirect_i = 0;
    redirect_pc_i = '0; imem_ack = 0;
    ack2 = 0; zero2 = 0; zpc2 = '0;

    // s f r rpc ack | req addr | v instr pc4
    vt[0]  = mk(0,0,0,0,1, 0,32'h3000, 0,B,B);
    vt[1]  = mk(0,0,0,0,1, 1,32'h3000,
                1,iw(32'h3000),32'h3004);
    vt[2]  = mk(0,0,0,0,1, 1,32'h3004,
                1,iw(32'h3004),32'h3008);
    vt[3]  = mk(1,0,0,0,1, 1,32'h3008,
                1,iw(32'h3004),32'h3008);
    vt[4]  = mk(1,0,0,0,0, 0,32'h300C,
                1,iw(32'h3004),32'h3008);
    vt[5]  = mk(1,0,0,0,0, 0,32'h300C,
                1,iw(32'h3004),32'h3008);
    vt[6]  = mk(0,0,0,0,0, 0,32'h300C,
                1,iw(32'h3008),32'h300C);
    vt[7]  = mk(0,0,0,0,0, 1,32'h300C, 0,B,B);
    vt[8]  = mk(0,1,1,32'h3040,0, 1,32'h300C, 0,B,B);
    vt[9]  = mk(0,0,0,0,0, 1,32'h300C, 0,B,B);
    vt[10] = mk(0,0,0,0,1, 1,32'h300C, 0,B,B);
    vt[11] = mk(0,0,0,0,1, 1,32'h3040,
                1,iw(32'h3040),32'h3044);
    vt[12] = mk(0,0,1,32'h3043,1, 1,32'h3044, 0,B,B);
    vt[13] = mk(0,0,0,0,1, 1,32'h3040,
                1,iw(32'h3040),32'h3044);
    vt[14] = mk(0,0,1,32'h3100,0, 1,32'h3044, 0,B,B);
    vt[15] = mk(0,0,1,32'h3200,0, 1,32'h3044, 0,B,B);
    vt[16] = mk(0,0,0,0,1, 1,32'h3044, 0,B,B);
    vt[17] = mk(0,0,0,0,1, 1,32'h3200,
                1,iw(32'h3200),32'h3204);
    vt[18] = mk(1,1,0,0,1, 1,32'h3204, 0,B,B);
    vt[19] = mk(0,0,0,0,0, 0,32'h3208,
                1,iw(32'h3204),32'h3208);

    @(posedge clk); #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", {31'b0, ID_valid}, 32'd0);
    chk("rst_instr", ID_instruction, 32'h0);
    chk("rst_pc4", ID_pc4, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      stall_i       = vt[i].stall;
      flush_i       = vt[i].flush;
      redirect_i    = vt[i].redir;
      redirect_pc_i = vt[i].rpc;
      imem_ack      = vt[i].ack;
      sb.push_back(vt[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_req", i),
          {31'b0, imem_req}, {31'b0, e.e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, e.e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i),
          {31'b0, ID_valid}, {31'b0, e.e_v});
      chk($sformatf("v%0d_instr", i),
          ID_instruction, e.e_instr);
      chk($sformatf("v%0d_pc4", i), ID_pc4, e.e_pc4);
    end

    // async reset while a dropped request is outstanding
    @(negedge clk);
    stall_i = 0; flush_i = 0;
    redirect_i = 1; redirect_pc_i = 32'h3300;
    imem_ack = 0;
    @(posedge clk); #1;
    redirect_i = 0;
    chk("drop_addr", imem_addr, 32'h3208);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h3000);
    chk("arst_valid", {31'b0, ID_valid}, 32'd0);
    chk("arst_pc4", ID_pc4, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h3000);
    @(negedge clk);
    imem_ack = 1;
    @(posedge clk); #1;
    imem_ack = 0;
    chk("restart_instr", ID_instruction, iw(32'h3000));
    chk("restart_pc4", ID_pc4, 32'h3004);

    // PC wrap at the top of the address space
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("wrap_req0", {31'b0, req2}, 32'd0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    ack2 = 1;
    #1;
    chk("wrap_req1", {31'b0, req2}, 32'd1);
    @(posedge clk); #1;
    chk("wrap_valid", {31'b0, valid2}, 32'd1);
    chk("wrap_instr", instr2, iw(32'hFFFF_FFFC));
    chk("wrap_pc4", pc4_2, 32'h0);
    chk("wrap_addr1", addr2, 32'h0);
    @(posedge clk); #1;
    ack2 = 0;
    chk("wrap_instr2", instr2, iw(32'h0));
    chk("wrap_pc4_2", pc4_2, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
